fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream.sv | 101 ++++++++++
 tb/tb_fifo_rd_stream.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: async-FIFO read side to valid/ready stream via a 2-entry buffer.
// Optional sequence checker is built only when SEQ_CHECK_EN is defined.
module fifo_rd_stream #(
  parameter int DATA_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     rd_clk,
  input  logic                     rd_rstn,
  output logic                     rd_en,
  input  logic                     rd_empty,
  input  logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_WIDTH-1:0]    m_data,
  input  logic                     clr,
  output logic                     seq_err,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  logic [DATA_WIDTH-1:0] buf_q [2];
  logic [1:0]            occ_q, occ_d;
  logic                  wr_ptr_q, rd_ptr_q;
  logic                  pend_q;
  logic                  pop;
  logic [2:0]            fill;

  assign m_valid = (occ_q != 2'd0);
  assign m_data  = buf_q[rd_ptr_q];
  assign pop     = m_valid & m_ready;
  assign fill    = {1'b0, occ_q} + {2'b0, pend_q} - {2'b0, pop};
  // Gated by reset so the FIFO is never read while held in reset
  assign rd_en   = rd_rstn & ~rd_empty & (fill < 3'd2);

  always_comb begin
    occ_d = occ_q;
    case ({pend_q, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      occ_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      pend_q <= rd_en;
      occ_q  <= occ_d;
      if (pend_q) begin
        buf_q[wr_ptr_q] <= rd_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

`ifdef SEQ_CHECK_EN
  logic                     primed_q;
  logic [DATA_WIDTH-1:0]    exp_q;
  logic                     seq_err_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
  logic                     miss;

  assign miss    = pop & primed_q & (m_data != exp_q);
  assign seq_err = seq_err_q;
  assign err_cnt = err_cnt_q;

  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      primed_q  <= 1'b0;
      exp_q     <= '0;
      seq_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else if (clr) begin
      primed_q  <= 1'b0;
      seq_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else if (pop) begin
      primed_q <= 1'b1;
      exp_q    <= m_data + DATA_WIDTH'(1);
      if (miss) begin
        seq_err_q <= 1'b1;
        if (err_cnt_q != '1)
          err_cnt_q <= err_cnt_q + ERR_CNT_WIDTH'(1);
      end
    end
  end
`else
  logic unused_clr;

  assign unused_clr = clr;
  assign seq_err    = 1'b0;
  assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: queue-based model of FIFO, buffer and checker.
// Directed scenarios followed by randomized traffic.
module tb_fifo_rd_stream;
  localparam int DW = 8;
  localparam int EW = 2;
`ifdef SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rd_en;
  logic          rd_empty = 1'b1;
  logic [DW-1:0] rd_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          clr = 1'b0;
  logic          seq_err;
  logic [EW-1:0] err_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  fifo_rd_stream #(
    .DATA_WIDTH(DW),
    .ERR_CNT_WIDTH(EW)
  ) dut (
    .rd_clk(clk),
    .rd_rstn(rstn),
    .rd_en(rd_en),
    .rd_empty(rd_empty),
    .rd_data(rd_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .clr(clr),
    .seq_err(seq_err),
    .err_cnt(err_cnt)
  );

  logic [DW-1:0] fifo[$];
  logic [DW-1:0] mq[$];
  logic [DW-1:0] beats[$];
  bit            m_pend;
  logic [DW-1:0] nxt_data;
  bit            pr;
  logic [DW-1:0] ex;
  bit            serr;
  int            ecnt;

  bit            last_valid, last_rden, last_pop, last_serr;
  logic [DW-1:0] last_mdata, last_beat;
  int            last_ecnt;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input bit rdy, input bit c);
    bit pop;
    bit exp_en;
    int room;
    m_ready  = rdy;
    clr      = c;
    rd_empty = (fifo.size() == 0);
    rd_data  = nxt_data;
    #1;
    pop    = (mq.size() != 0) && rdy;
    room   = mq.size() + int'(m_pend) - int'(pop);
    exp_en = !rd_empty && (room < 2);
    chk("m_valid", int'(m_valid), int'(mq.size() != 0));
    if (mq.size() != 0) chk("m_data", int'(m_data), int'(mq[0]));
    chk("rd_en", int'(rd_en), int'(exp_en));
    chk("seq_err", int'(seq_err), CHK ? int'(serr) : 0);
    chk("err_cnt", int'(err_cnt), CHK ? ecnt : 0);
    last_valid = m_valid;
    last_mdata = m_data;
    last_rden  = rd_en;
    last_pop   = pop;
    last_serr  = seq_err;
    last_ecnt  = int'(err_cnt);
    last_beat  = pop ? mq[0] : '0;
    if (pop) beats.push_back(mq[0]);
    if (c) begin
      pr = 0; serr = 0; ecnt = 0;
    end else if (pop) begin
      if (pr && mq[0] != ex) begin
        serr = 1;
        if (ecnt < 2**EW - 1) ecnt++;
      end
      ex = mq[0] + DW'(1);
      pr = 1;
    end
    if (pop) void'(mq.pop_front());
    if (m_pend) mq.push_back(rd_data);
    m_pend   = exp_en;
    nxt_data = DW'($urandom);
    if (rd_en && fifo.size() != 0) nxt_data = fifo.pop_front();
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_seq_err", int'(seq_err), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    fifo.delete();
    mq.delete();
    m_pend = 0; pr = 0; serr = 0; ecnt = 0;
    nxt_data = DW'($urandom);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (fifo.size() == 0 && mq.size() == 0 && !m_pend) break;
      step(1, 0);
    end
    chk("drain_done", int'(fifo.size() + mq.size() + int'(m_pend)), 0);
  endtask

  initial begin
    int first_en, first_v, first_p, last_p, held, pulses, e_at5;
    logic [DW-1:0] sq;
    logic [DW-1:0] wv [5];
    wv[0] = 8'hFE; wv[1] = 8'hFF; wv[2] = 8'h00;
    wv[3] = 8'h05; wv[4] = 8'h06;
    nxt_data = '0;
    @(negedge clk);
    do_reset();

    // streaming
    for (int i = 0; i < 16; i++) fifo.push_back(DW'(i));
    beats.delete();
    first_en = -1; first_v = -1; first_p = -1; last_p = -1;
    for (int k = 0; k < 30; k++) begin
      step(1, 0);
      if (last_rden && first_en < 0) first_en = k;
      if (last_valid && first_v < 0) first_v = k;
      if (last_pop) begin
        if (first_p < 0) first_p = k;
        last_p = k;
      end
    end
    chk("stream_latency", first_v - first_en, 2);
    chk("stream_count", beats.size(), 16);
    chk("stream_consec", last_p - first_p, 15);
    for (int i = 0; i < 16 && i < beats.size(); i++)
      chk("stream_beat", int'(beats[i]), i);
    chk("stream_seq_err", int'(last_serr), 0);

    // backpressure
    for (int i = 0; i < 32; i++) fifo.push_back(DW'(8'h10 + i));
    beats.delete();
    held = 0;
    for (int k = 0; k < 5; k++) step(1, 0);
    for (int k = 0; k < 10; k++) begin
      step(0, 0);
      if (k == 0) held = int'(last_mdata);
    end
    chk("bp_rd_en", int'(last_rden), 0);
    chk("bp_valid", int'(last_valid), 1);
    chk("bp_hold", int'(last_mdata), held);
    chk("bp_occ", mq.size(), 2);
    drain(100);
    chk("bp_count", beats.size(), 32);
    for (int i = 0; i < beats.size(); i++)
      chk("bp_beat", int'(beats[i]), 8'h10 + i);

    // empty boundary
    for (int k = 0; k < 3; k++) step(1, 0);
    fifo.push_back(8'h30);
    beats.delete();
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      step(1, 0);
      if (last_rden) pulses++;
    end
    chk("empty_pulses", pulses, 1);
    chk("empty_beats", beats.size(), 1);
    if (beats.size() > 0) chk("empty_beat", int'(beats[0]), 8'h30);

    // wrap and error
    step(1, 1);
    for (int i = 0; i < 5; i++) fifo.push_back(wv[i]);
    e_at5 = -1;
    for (int k = 0; k < 10; k++) begin
      step(1, 0);
      if (last_pop && last_beat == 8'h05) e_at5 = last_ecnt;
    end
    chk("wrap_no_err", e_at5, 0);
    chk("wrap_err_cnt", last_ecnt, CHK ? 1 : 0);
    chk("wrap_seq_err", int'(last_serr), CHK ? 1 : 0);

    // saturation and clr
    step(1, 1);
    for (int i = 1; i <= 6; i++) fifo.push_back(DW'(i * 16));
    for (int k = 0; k < 12; k++) step(1, 0);
    chk("sat_err_cnt", last_ecnt, CHK ? 3 : 0);
    chk("sat_seq_err", int'(last_serr), CHK ? 1 : 0);
    step(1, 1);
    step(1, 0);
    chk("clr_err_cnt", last_ecnt, 0);
    chk("clr_seq_err", int'(last_serr), 0);
    fifo.push_back(8'h99);
    fifo.push_back(8'h9A);
    for (int k = 0; k < 8; k++) step(1, 0);
    chk("clr_unchecked", last_ecnt, 0);

    // reset mid-stream
    for (int i = 0; i < 8; i++) fifo.push_back(DW'(8'h40 + i));
    for (int k = 0; k < 6; k++) step(0, 0);
    chk("mid_occ", mq.size(), 2);
    chk("mid_valid", int'(last_valid), 1);
    fifo.push_back(8'h55);
    rd_empty = 1'b0;
    do_reset();

    // random traffic
    sq = '0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        sq = ($urandom_range(0, 15) == 0) ? DW'($urandom) : sq + DW'(1);
        fifo.push_back(sq);
      end
      if (k == 1500) do_reset();
      step($urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
    end
    drain(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
